// File: rtl/as2650_pkg.sv
// as2650_pkg: shared FSM states, requester IDs and bus widths for the AS2650 bus arbiter
package as2650_pkg;
    localparam int ADR_W = 13;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, DONE} arb_state_t;
    typedef enum logic {REQ_CPU = 1'b0, REQ_DMA = 1'b1} req_id_t;
endpackage

// File: rtl/as2650_rr_pick.sv
// as2650_rr_pick: two-input round-robin grant; a tie goes to whoever was not served last
module as2650_rr_pick
    import as2650_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    cpu_req,
    input  logic    dma_req,
    input  logic    upd,
    input  req_id_t served,
    output req_id_t grant
);
    req_id_t last_grant;
    always_ff @(posedge clk or posedge reset)
        if (reset) last_grant <= REQ_DMA;
        else if (upd) last_grant <= served;
    always_comb
        grant = (cpu_req && dma_req) ? ((last_grant == REQ_DMA) ? REQ_CPU : REQ_DMA)
                                     : (dma_req ? REQ_DMA : REQ_CPU);
endmodule

// File: rtl/as2650_bus_arb.sv
// as2650_bus_arb: arbitrates CPU and DMA accesses onto one shared memory with fixed wait states
module as2650_bus_arb
    import as2650_pkg::*;
#(
    parameter int WAIT_STATES = 1
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_opreq,
    input  logic [ADR_W-1:0]  cpu_adr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_opack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADR_W-1:0]  dma_adr,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic              mem_oe
);
    localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);
    arb_state_t        state, state_nx;
    req_id_t           grant, owner;
    logic [2:0]        wait_cnt;
    logic              any_req, acc, last_acc, lat_we;
    logic [ADR_W-1:0]  lat_adr;
    logic [DATA_W-1:0] lat_wdata;
    assign any_req  = cpu_opreq | dma_req;
    assign acc      = (state == CPU_ACC) || (state == DMA_ACC);
    assign last_acc = acc && (wait_cnt == LAST_CNT);
    assign mem_adr   = lat_adr;
    assign mem_wdata = lat_wdata;
    assign mem_oe    = mem_ce & ~mem_we;
    as2650_rr_pick u_pick (
        .clk    (clk),
        .reset  (reset),
        .cpu_req(cpu_opreq),
        .dma_req(dma_req),
        .upd    (last_acc),
        .served (owner),
        .grant  (grant)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    // mem strobes come from state only, so an async reset drops them at once
    always_comb begin
        state_nx  = state;
        cpu_opack = 1'b0;
        dma_ack   = 1'b0;
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: state_nx = any_req ? ((grant == REQ_DMA) ? DMA_ACC : CPU_ACC) : IDLE;
            CPU_ACC, DMA_ACC: begin
                mem_ce   = 1'b1;
                mem_we   = lat_we;
                state_nx = (wait_cnt == LAST_CNT) ? DONE : state;
            end
            DONE: begin
                cpu_opack = (owner == REQ_CPU);
                dma_ack   = (owner == REQ_DMA);
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wait_cnt  <= 3'd0;
            owner     <= REQ_CPU;
            lat_adr   <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            wait_cnt <= (acc && !last_acc) ? wait_cnt + 3'd1 : 3'd0;
            if (state == IDLE && any_req) begin
                owner     <= grant;
                lat_adr   <= (grant == REQ_DMA) ? dma_adr : cpu_adr;
                lat_we    <= (grant == REQ_DMA) ? dma_we : cpu_rw;
                lat_wdata <= (grant == REQ_DMA) ? dma_wdata : cpu_wdata;
            end
            if (last_acc && !lat_we && owner == REQ_CPU) cpu_rdata <= mem_rdata;
            if (last_acc && !lat_we && owner == REQ_DMA) dma_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_as2650_bus_arb.sv
// tb_as2650_bus_arb: three arbiters (0, 1 and 7 wait states) checked every cycle against a timeline model
module tb_as2650_bus_arb;
    localparam int WSV [3] = '{0, 1, 7};
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  creq, dreq, cack, dack, ce, we, oe;
    logic [12:0] cpu_adr, dma_adr;
    logic        cpu_rw, dma_we;
    logic [7:0]  cpu_wdata, dma_wdata, mem_rdata;
    logic [7:0]  crd [3];
    logic [7:0]  drd [3];
    logic [7:0]  mwd [3];
    logic [12:0] madr [3];
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : u
        as2650_bus_arb #(.WAIT_STATES(WSV[g])) dut (
            .clk      (clk),
            .reset    (reset),
            .cpu_opreq(creq[g]),
            .cpu_adr  (cpu_adr),
            .cpu_rw   (cpu_rw),
            .cpu_wdata(cpu_wdata),
            .cpu_opack(cack[g]),
            .cpu_rdata(crd[g]),
            .dma_req  (dreq[g]),
            .dma_adr  (dma_adr),
            .dma_we   (dma_we),
            .dma_wdata(dma_wdata),
            .dma_ack  (dack[g]),
            .dma_rdata(drd[g]),
            .mem_adr  (madr[g]),
            .mem_wdata(mwd[g]),
            .mem_rdata(mem_rdata),
            .mem_ce   (ce[g]),
            .mem_we   (we[g]),
            .mem_oe   (oe[g])
        );
    end
    // model: each access is a window of cycle numbers [acc_lo, acc_hi] followed by the ack cycle
    int          cyc = 0;
    int          acc_lo [3] = '{0, 0, 0};
    int          acc_hi [3] = '{-1, -1, -1};
    int          ack_c [3] = '{-1, -1, -1};
    bit          win [3] = '{0, 0, 0};
    bit          last [3] = '{1, 1, 1};
    bit          m_we [3] = '{0, 0, 0};
    logic [12:0] m_adr [3] = '{0, 0, 0};
    logic [7:0]  m_wd [3] = '{0, 0, 0};
    logic [7:0]  m_crd [3] = '{0, 0, 0};
    logic [7:0]  m_drd [3] = '{0, 0, 0};
    function automatic bit pick(bit c, bit d, bit l);
        return (c && d) ? !l : d;
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                acc_lo[i] <= 0;
                acc_hi[i] <= -1;
                ack_c[i]  <= -1;
                win[i]    <= 1'b0;
                last[i]   <= 1'b1;
                m_we[i]   <= 1'b0;
                m_adr[i]  <= '0;
                m_wd[i]   <= '0;
                m_crd[i]  <= '0;
                m_drd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cyc == acc_hi[i]) begin
                    if (!m_we[i] && !win[i]) m_crd[i] <= mem_rdata;
                    if (!m_we[i] && win[i]) m_drd[i] <= mem_rdata;
                    last[i] <= win[i];
                end
                if (cyc > ack_c[i] && (creq[i] || dreq[i])) begin
                    win[i]    <= pick(creq[i], dreq[i], last[i]);
                    m_adr[i]  <= pick(creq[i], dreq[i], last[i]) ? dma_adr : cpu_adr;
                    m_we[i]   <= pick(creq[i], dreq[i], last[i]) ? dma_we : cpu_rw;
                    m_wd[i]   <= pick(creq[i], dreq[i], last[i]) ? dma_wdata : cpu_wdata;
                    acc_lo[i] <= cyc + 1;
                    acc_hi[i] <= cyc + 1 + WSV[i];
                    ack_c[i]  <= cyc + 2 + WSV[i];
                end
            end
            cyc <= cyc + 1;
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic cmp_all();
        for (int i = 0; i < 3; i++) begin
            bit e_ce;
            e_ce = (cyc >= acc_lo[i]) && (cyc <= acc_hi[i]);
            chk($sformatf("mem_ce[%0d]", i), ce[i], e_ce);
            chk($sformatf("mem_we[%0d]", i), we[i], e_ce && m_we[i]);
            chk($sformatf("mem_oe[%0d]", i), oe[i], e_ce && !m_we[i]);
            chk($sformatf("mem_adr[%0d]", i), madr[i], m_adr[i]);
            chk($sformatf("mem_wdata[%0d]", i), mwd[i], m_wd[i]);
            chk($sformatf("cpu_opack[%0d]", i), cack[i], (cyc == ack_c[i]) && !win[i]);
            chk($sformatf("dma_ack[%0d]", i), dack[i], (cyc == ack_c[i]) && win[i]);
            chk($sformatf("cpu_rdata[%0d]", i), crd[i], m_crd[i]);
            chk($sformatf("dma_rdata[%0d]", i), drd[i], m_drd[i]);
        end
    endtask
    task automatic access(input int i, input bit d, input bit wr, input logic [12:0] a,
                          input logic [7:0] wd, input logic [7:0] rd, output int lat,
                          output int nce, output int nwe, output logic [12:0] sa, output logic [7:0] sw);
        lat = -1;
        nce = 0;
        nwe = 0;
        sa = '0;
        sw = '0;
        @(posedge clk); #1;
        mem_rdata = rd;
        if (d) begin
            dma_adr = a; dma_we = wr; dma_wdata = wd; dreq[i] = 1'b1;
        end else begin
            cpu_adr = a; cpu_rw = wr; cpu_wdata = wd; creq[i] = 1'b1;
        end
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (ce[i]) nce++;
            if (we[i]) begin nwe++; sa = madr[i]; sw = mwd[i]; end
            if (d ? dack[i] : cack[i]) lat = k;
            @(posedge clk); #1;
        end
        creq[i] = 1'b0;
        dreq[i] = 1'b0;
        chk($sformatf("ack_seen[%0d]", i), lat >= 0, 1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat, nce, nwe, n;
        logic [12:0] sa;
        logic [7:0] sw;
        logic [3:0] seq;
        creq = '0; dreq = '0; cpu_adr = '0; dma_adr = '0; cpu_rw = 0; dma_we = 0;
        cpu_wdata = '0; dma_wdata = '0; mem_rdata = '0;
        fork
            forever begin
                @(negedge clk);
                cmp_all();
            end
        join_none
        repeat (3) @(negedge clk);
        chk("rst_ce", ce[1], 0);
        chk("rst_cpu_rdata", crd[1], 0);
        chk("rst_dma_rdata", drd[0], 0);
        @(posedge clk); #1 reset = 1'b0;
        // both request together right after reset: CPU first, then strict alternation
        @(posedge clk); #1;
        cpu_adr = 13'h0100; dma_adr = 13'h0200; cpu_rw = 0; dma_we = 0; mem_rdata = 8'h3C;
        creq[1] = 1'b1; dreq[1] = 1'b1;
        n = 0; seq = '0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            @(negedge clk);
            if (cack[1] || dack[1]) begin seq[n[1:0]] = dack[1]; n++; end
        end
        @(posedge clk); #1;
        creq[1] = 1'b0; dreq[1] = 1'b0;
        chk("rr_count", n, 4);
        chk("rr_order", seq, 4'b1010);
        access(1, 0, 0, 13'h0123, 8'h00, 8'hA5, lat, nce, nwe, sa, sw);
        chk("ws1_read_latency", lat, 3);
        chk("ws1_read_ce_cycles", nce, 2);
        chk("ws1_read_we_cycles", nwe, 0);
        chk("ws1_read_rdata", crd[1], 8'hA5);
        // request dropped while the access is already running
        @(posedge clk); #1;
        cpu_adr = 13'h0042; cpu_rw = 0; mem_rdata = 8'h77; creq[1] = 1'b1;
        @(posedge clk); #1;
        creq[1] = 1'b0;
        n = 0;
        repeat (8) begin @(negedge clk); if (cack[1]) n++; end
        chk("drop_ack_count", n, 1);
        chk("drop_idle_ce", ce[1], 0);
        chk("drop_rdata", crd[1], 8'h77);
        access(0, 1, 1, 13'h1FFF, 8'h5A, 8'h00, lat, nce, nwe, sa, sw);
        chk("ws0_write_we_cycles", nwe, 1);
        chk("ws0_write_adr", sa, 13'h1FFF);
        chk("ws0_write_wdata", sw, 8'h5A);
        chk("ws0_write_latency", lat, 2);
        access(2, 0, 1, 13'h0777, 8'hC3, 8'h00, lat, nce, nwe, sa, sw);
        chk("ws7_write_ce_cycles", nce, 8);
        chk("ws7_write_latency", lat, 9);
        access(2, 1, 0, 13'h0888, 8'h00, 8'h96, lat, nce, nwe, sa, sw);
        chk("ws7_read_ce_cycles", nce, 8);
        chk("ws7_read_rdata", drd[2], 8'h96);
        // reset lands in the second cycle of a DMA write
        @(posedge clk); #1;
        dma_adr = 13'h0AAA; dma_we = 1; dma_wdata = 8'h11; dreq[1] = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_we_first", we[1], 1);
        @(posedge clk); #1;
        chk("rst_mid_ce_second", ce[1], 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_ce_async", ce[1], 0);
        chk("rst_mid_we_async", we[1], 0);
        chk("rst_mid_adr_async", madr[1], 0);
        dreq[1] = 1'b0;
        n = 0;
        repeat (3) begin @(negedge clk); if (dack[1]) n++; end
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) begin @(negedge clk); if (dack[1]) n++; end
        chk("rst_mid_no_ack", n, 0);
        access(1, 0, 0, 13'h0456, 8'h00, 8'h5B, lat, nce, nwe, sa, sw);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_rdata", crd[1], 8'h5B);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
